// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg
// Shared types for the cache round-robin arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   arb_rw_t    : direction of the latched line request (ARB_RD, ARB_WR)
//   idx_width() : bit width needed to index N requesters (at least 1)
package cache_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_RD = 1'b0,
    ARB_WR = 1'b1
  } arb_rw_t;

  // A single requester still needs a 1-bit index so that the pointer and
  // winner registers stay legal vectors.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin selection. Scans pending requesters starting at
// ptr_i and wrapping modulo N_REQ; reports the first pending index found.
// Ports:
//   pending_i [N_REQ]  per-requester pending flag
//   ptr_i     [IDX_W]  index with highest priority this round (< N_REQ)
//   valid_o            at least one requester is pending
//   winner_o  [IDX_W]  selected requester index (0 when valid_o is low)
module rr_picker
  import cache_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] winner_o
);

  logic [IDX_W-1:0] rot_idx [N_REQ];
  logic [N_REQ-1:0] hit;

  // rot_idx[k] is the requester examined at scan offset k. The wrap is an
  // explicit subtraction, so N_REQ does not need to be a power of two.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum         = {1'b0, ptr_i} + (IDX_W + 1)'(gi);
    assign rot_idx[gi] = (sum >= (IDX_W + 1)'(N_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(N_REQ))
                                                      : IDX_W'(sum);
    assign hit[gi]     = pending_i[rot_idx[gi]];
  end

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid_o  = 1'b1;
        winner_o = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/cache_rr_arbiter.sv
// cache_rr_arbiter
// N-port round-robin arbiter between L1 caches / prefetchers and a single
// shared L2 line port. A request is sampled in IDLE, latched (rw, address,
// write line) and held stable on the L2 side until l2_resp; the pointer then
// moves to the requester after the winner. One bubble cycle separates
// transactions.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_read/req_write  per-requester line read / write request
//   req_address         per-requester line address
//   req_wdata           per-requester write line
//   req_resp            one-hot completion pulse to the granted requester
//   req_rdata           read line broadcast (direct copy of l2_rdata)
//   l2_read/l2_write    downstream request, held until l2_resp
//   l2_address/l2_wdata latched address / write line of the granted request
//   l2_resp, l2_rdata   downstream completion pulse and read line
//   perf_grants         grants per requester        (CACHE_ARB_PERF_EN)
//   perf_wait_cycles    cycles with a waiting requester (CACHE_ARB_PERF_EN)
// Optional feature: define CACHE_ARB_PERF_EN to add the saturating
// performance counters and their ports.
module cache_rr_arbiter
  import cache_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int S_LINE = 256,
  parameter int CNT_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_read,
  input  logic [N_REQ-1:0]               req_write,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_address,
  input  logic [N_REQ-1:0][S_LINE-1:0]   req_wdata,
  output logic [N_REQ-1:0]               req_resp,
  output logic [S_LINE-1:0]              req_rdata,
  output logic                           l2_read,
  output logic                           l2_write,
  output logic [ADDR_W-1:0]              l2_address,
  output logic [S_LINE-1:0]              l2_wdata,
  input  logic                           l2_resp,
  input  logic [S_LINE-1:0]              l2_rdata
`ifdef CACHE_ARB_PERF_EN
  ,
  output logic [N_REQ-1:0][CNT_W-1:0]    perf_grants,
  output logic [CNT_W-1:0]               perf_wait_cycles
`endif
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  ptr_d;
  logic [IDX_W-1:0]  winner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [S_LINE-1:0] wdata_q;
  logic              l2_read_q;
  logic              l2_write_q;

  logic [N_REQ-1:0]  pending;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_winner;
  arb_rw_t           pick_rw;
  logic              resp_fire;

  assign pending = req_read | req_write;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .pending_i (pending),
    .ptr_i     (ptr_q),
    .valid_o   (pick_valid),
    .winner_o  (pick_winner)
  );

  // Read and write together is illegal from a cache; the write wins.
  assign pick_rw   = req_write[pick_winner] ? ARB_WR : ARB_RD;
  assign resp_fire = (state_q == BUSY) && l2_resp;

  // Rotate to the requester after the one just served.
  assign ptr_d = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      winner_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            winner_q   <= pick_winner;
            addr_q     <= req_address[pick_winner];
            wdata_q    <= req_wdata[pick_winner];
            l2_read_q  <= (pick_rw == ARB_RD);
            l2_write_q <= (pick_rw == ARB_WR);
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // Requester inputs are ignored here; only the L2 completion matters.
          if (l2_resp) begin
            ptr_q      <= ptr_d;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign req_rdata  = l2_rdata;

  // Completion is combinational with l2_resp so the cache sees it the same cycle.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp
    assign req_resp[gi] = resp_fire && (winner_q == IDX_W'(gi));
  end

`ifdef CACHE_ARB_PERF_EN
  logic [N_REQ-1:0][CNT_W-1:0] grant_cnt_q;
  logic [CNT_W-1:0]            wait_cnt_q;
  logic [N_REQ-1:0]            grant_hit;
  logic [N_REQ-1:0]            cur_mask;
  logic                        wait_hit;

  // cur_mask marks the requester currently being served (BUSY) or being
  // granted this cycle (IDLE); anyone else pending is waiting.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
    assign grant_hit[gi] = (state_q == IDLE) && pick_valid && (pick_winner == IDX_W'(gi));
    assign cur_mask[gi]  = (state_q == BUSY) ? (winner_q == IDX_W'(gi)) : grant_hit[gi];
  end

  assign wait_hit = |(pending & ~cur_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_hit[i] && !(&grant_cnt_q[i])) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + CNT_W'(1);
        end
      end
      if (wait_hit && !(&wait_cnt_q)) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_grants      = grant_cnt_q;
  assign perf_wait_cycles = wait_cnt_q;
`endif

endmodule

// File: tb/tb_cache_rr_arbiter.sv
// tb_cache_rr_arbiter
// Directed scoreboard bench for cache_rr_arbiter (N_REQ=3). Requester and L2
// models drive the DUT; each expected L2 transaction is queued when the
// stimulus is issued and a monitor checks issues, holds and completions.
module tb_cache_rr_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 32;
  localparam int S_LINE = 256;
  localparam int CNT_W  = 32;
  localparam int L2_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]             req_read;
  logic [N_REQ-1:0]             req_write;
  logic [N_REQ-1:0][ADDR_W-1:0] req_address;
  logic [N_REQ-1:0][S_LINE-1:0] req_wdata;
  logic [N_REQ-1:0]             req_resp;
  logic [S_LINE-1:0]            req_rdata;
  logic                         l2_read;
  logic                         l2_write;
  logic [ADDR_W-1:0]            l2_address;
  logic [S_LINE-1:0]            l2_wdata;
  logic                         l2_resp;
  logic [S_LINE-1:0]            l2_rdata;
`ifdef CACHE_ARB_PERF_EN
  logic [N_REQ-1:0][CNT_W-1:0]  perf_grants;
  logic [CNT_W-1:0]             perf_wait_cycles;
`endif

  cache_rr_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .S_LINE (S_LINE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_resp    (req_resp),
    .req_rdata   (req_rdata),
    .l2_read     (l2_read),
    .l2_write    (l2_write),
    .l2_address  (l2_address),
    .l2_wdata    (l2_wdata),
    .l2_resp     (l2_resp),
    .l2_rdata    (l2_rdata)
`ifdef CACHE_ARB_PERF_EN
    ,
    .perf_grants      (perf_grants),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [S_LINE-1:0] wdata;
    bit                scramble;  // change addr/wdata after the first driven cycle
  } req_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [S_LINE-1:0] wdata;
    logic [N_REQ-1:0]  onehot;
    logic [S_LINE-1:0] rdata;
    int                gap;       // cycles from previous completion to issue, -1 = unchecked
  } exp_t;

  req_t port_q [N_REQ][$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit resp_en    = 1'b1;
  bit idle_pulse = 1'b0;
  bit mon_active = 1'b0;

  task automatic chk(input string name, input logic [S_LINE-1:0] act, input logic [S_LINE-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Line returned by the L2 model for a given address.
  function automatic logic [S_LINE-1:0] l2_line(input logic [ADDR_W-1:0] a);
    if (a == 32'h0000_1000) return {32{8'hA5}};
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic push_req(input int p, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [S_LINE-1:0] wd, input bit scr);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd; r.scramble = scr;
    port_q[p].push_back(r);
  endtask

  task automatic push_exp(input int p, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [S_LINE-1:0] wd, input int gap);
    exp_t e;
    e.wr = wr; e.addr = a; e.wdata = wd;
    e.onehot = N_REQ'(1) << p;
    e.rdata = l2_line(a);
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Requester model: each port drives the head of its queue and retires it
  // after seeing its own req_resp.
  initial begin
    bit   flag [N_REQ];
    int   age  [N_REQ];
    req_t r;
    for (int i = 0; i < N_REQ; i++) begin flag[i] = 1'b0; age[i] = 0; end
    req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (flag[i] && port_q[i].size() > 0) begin
          void'(port_q[i].pop_front());
          age[i] = 0;
        end
        flag[i] = 1'b0;
        if (port_q[i].size() > 0) begin
          r = port_q[i][0];
          req_read[i]    = r.rd;
          req_write[i]   = r.wr;
          req_address[i] = (r.scramble && age[i] > 0) ? (r.addr ^ 32'hFFFF_0000) : r.addr;
          req_wdata[i]   = (r.scramble && age[i] > 0) ? ~r.wdata : r.wdata;
          age[i]++;
        end else begin
          req_read[i] = 1'b0; req_write[i] = 1'b0;
          req_address[i] = '0; req_wdata[i] = '0;
          age[i] = 0;
        end
      end
      #3;
      for (int i = 0; i < N_REQ; i++) flag[i] = req_resp[i];
    end
  end

  // L2 model: completes each request L2_LAT cycles after issue; can also
  // emit a stray pulse while idle.
  initial begin
    int cnt = 0;
    l2_resp = 1'b0;
    l2_rdata = '0;
    forever begin
      @(negedge clk);
      l2_resp = 1'b0;
      if (idle_pulse && !(l2_read || l2_write)) begin
        l2_resp  = 1'b1;
        l2_rdata = {8{32'hDEAD_BEEF}};
        cnt = 0;
      end else if ((l2_read || l2_write) && resp_en) begin
        cnt++;
        if (cnt >= L2_LAT) begin
          l2_resp  = 1'b1;
          l2_rdata = l2_line(l2_address);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t cur;
    bit   prev_rst = 1'b1;
    int   cyc = 0;
    int   last_resp = -1;
    int   txn = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (prev_rst) begin
        chk("rst_l2_rw", S_LINE'({l2_read, l2_write}), '0);
        chk("rst_l2_address", S_LINE'(l2_address), '0);
        chk("rst_l2_wdata", l2_wdata, '0);
        chk("rst_req_resp", S_LINE'(req_resp), '0);
        mon_active = 1'b0;
        last_resp = -1;
      end else begin
        if (l2_resp && !(l2_read || l2_write)) begin
          chk("idle_resp_ignored", S_LINE'(req_resp), '0);
        end
        if ((l2_read || l2_write) && !mon_active) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_issue: got request addr %h, required no request", l2_address);
          end else begin
            cur = exp_q.pop_front();
            mon_active = 1'b1;
            chk("issue_rw", S_LINE'({l2_read, l2_write}), S_LINE'(cur.wr ? 2'b01 : 2'b10));
            chk("issue_addr", S_LINE'(l2_address), S_LINE'(cur.addr));
            if (cur.wr) chk("issue_wdata", l2_wdata, cur.wdata);
            if (cur.gap >= 0 && last_resp >= 0) chk("bubble_gap", S_LINE'(cyc - last_resp), S_LINE'(cur.gap));
          end
        end else if (mon_active) begin
          chk("hold_rw", S_LINE'({l2_read, l2_write}), S_LINE'(cur.wr ? 2'b01 : 2'b10));
          chk("hold_addr", S_LINE'(l2_address), S_LINE'(cur.addr));
          if (cur.wr) chk("hold_wdata", l2_wdata, cur.wdata);
        end
        if (req_resp != '0) begin
          if (!mon_active) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got req_resp %b, required 0", req_resp);
          end else begin
            chk("resp_onehot", S_LINE'(req_resp), S_LINE'(cur.onehot));
            chk("resp_rdata", req_rdata, cur.rdata);
            txn++;
            $display("txn %0d: req_resp=%b %s addr=%h", txn, req_resp, cur.wr ? "WR" : "RD", cur.addr);
            mon_active = 1'b0;
            last_resp = cyc;
          end
        end
      end
      prev_rst = rst;
    end
  end

  task automatic drain(input string name);
    int t = 0;
    bit busy = 1'b1;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
      busy = mon_active || (exp_q.size() > 0);
      for (int i = 0; i < N_REQ; i++) if (port_q[i].size() > 0) busy = 1'b1;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_timeout: got still busy after %0d cycles, required drained", name, t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single read from port 1 (ptr 0 -> port 1 is the first pending).
    push_exp(1, 1'b0, 32'h0000_1000, '0, -1);
    push_req(1, 1'b1, 1'b0, 32'h0000_1000, '0, 1'b0);
    drain("single_read");

    // All three ports pending continuously from reset: order 0,1,2,0,1,2.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < N_REQ; p++) begin
        push_exp(p, 1'b0, ADDR_W'(32'h100 * (1 + p + 3 * r)), '0, (r == 0 && p == 0) ? -1 : 2);
        push_req(p, 1'b1, 1'b0, ADDR_W'(32'h100 * (1 + p + 3 * r)), '0, 1'b0);
      end
    end
    drain("all_three");

    // Port 1 alone moves the pointer to 2.
    push_exp(1, 1'b0, 32'h0000_1800, '0, -1);
    push_req(1, 1'b1, 1'b0, 32'h0000_1800, '0, 1'b0);
    drain("ptr_to_2");

    // Port 2 write with inputs changing mid-transaction, port 0 waiting:
    // port 2 first, pointer wraps, port 0 after one bubble.
    push_exp(2, 1'b1, 32'h0000_2000, {8{32'hC0DE_0002}}, -1);
    push_exp(0, 1'b0, 32'h0000_3000, '0, 2);
    push_req(2, 1'b0, 1'b1, 32'h0000_2000, {8{32'hC0DE_0002}}, 1'b1);
    push_req(0, 1'b1, 1'b0, 32'h0000_3000, '0, 1'b0);
    drain("wrap");

    // Read and write together: write only.
    push_exp(0, 1'b1, 32'h0000_4000, {8{32'h1234_5678}}, -1);
    push_req(0, 1'b1, 1'b1, 32'h0000_4000, {8{32'h1234_5678}}, 1'b0);
    drain("rd_and_wr");

    // Reset during BUSY drops the transaction; afterwards port 0 beats port 1.
    resp_en = 1'b0;
    push_exp(1, 1'b0, 32'h0000_5000, '0, -1);
    push_req(1, 1'b1, 1'b0, 32'h0000_5000, '0, 1'b0);
    t = 0;
    while (!mon_active && t < 50) begin @(negedge clk); t++; end
    chk("busy_before_reset", S_LINE'(mon_active), S_LINE'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    port_q[1].delete();
    @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1;
    push_exp(0, 1'b0, 32'h0000_7000, '0, -1);
    push_exp(1, 1'b0, 32'h0000_6000, '0, 2);
    push_req(1, 1'b1, 1'b0, 32'h0000_6000, '0, 1'b0);
    push_req(0, 1'b1, 1'b0, 32'h0000_7000, '0, 1'b0);
    drain("after_reset");

    // Stray L2 completion while idle must not produce req_resp.
    @(posedge clk);
    idle_pulse = 1'b1;
    @(posedge clk);
    idle_pulse = 1'b0;
    repeat (4) @(negedge clk);

`ifdef CACHE_ARB_PERF_EN
    // Four rounds of three ports from reset: four grants each.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < N_REQ; p++) begin
        push_exp(p, 1'b0, ADDR_W'(32'h8000 + 32'h40 * (p + 3 * r)), '0, (r == 0 && p == 0) ? -1 : 2);
        push_req(p, 1'b1, 1'b0, ADDR_W'(32'h8000 + 32'h40 * (p + 3 * r)), '0, 1'b0);
      end
    end
    drain("perf_rounds");
    for (int p = 0; p < N_REQ; p++) begin
      chk($sformatf("perf_grants_%0d", p), S_LINE'(perf_grants[p]), S_LINE'(4));
    end
`endif

    chk("exp_queue_empty", S_LINE'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
